// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch-stage types and constants
package fetch_stage_pkg;
  localparam int IFID_XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} fetch_state_t;
  typedef struct packed {
    logic [IFID_XLEN-1:0] pc;
    logic [IFID_XLEN-1:0] pc_plus4;
    logic [31:0]          inst;
    logic                 valid;
  } ifid_t;
endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: pipeline register with load enable and synchronous clear to a NOP image
module ifid_reg #(
  parameter int           W   = 97,
  parameter logic [W-1:0] CLR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) o_q <= CLR;
    else if (i_clr) o_q <= CLR;
    else if (i_en) o_q <= i_d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem request/valid handshake and IF/ID register with stall/flush
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = fetch_stage_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            imem_valid_i,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_pc_plus4_o,
  output logic [31:0]     ifid_inst_o,
  output logic            ifid_valid_o
);
  import fetch_stage_pkg::*;
  localparam int W = 2*XLEN + 33;
  localparam logic [W-1:0] IFID_CLR = {{(2*XLEN){1'b0}}, NOP_INST, 1'b0};
  fetch_state_t    r_state, w_state;
  logic [XLEN-1:0] r_pc, w_pc, r_req_addr, w_req_addr;
  logic [31:0]     r_skid, w_skid;
  logic            r_run, w_valid, w_ld;
  logic [W-1:0]    w_ifid_d, w_ifid_q;
  assign pc_o        = r_pc;
  assign pc_plus4_o  = r_pc + XLEN'(4);
  assign imem_addr_o = r_req_addr;
  assign imem_req_o  = r_run && (r_state != HOLD);
  assign w_valid     = imem_req_o && imem_valid_i;
  assign {ifid_pc_o, ifid_pc_plus4_o, ifid_inst_o, ifid_valid_o} = w_ifid_q;
  // a flush with nothing outstanding can redirect at once; otherwise the old response must drain
  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_req_addr = r_req_addr;
    w_skid     = r_skid;
    w_ld       = 1'b0;
    w_ifid_d   = {r_pc, pc_plus4_o, r_skid, 1'b1};
    if (flush_i) begin
      w_pc   = next_pc_i;
      w_skid = '0;
      if (r_state != DISCARD && (!imem_req_o || w_valid)) begin
        w_state    = FETCH;
        w_req_addr = next_pc_i;
      end else w_state = DISCARD;
    end else case (r_state)
      FETCH:
        if (w_valid && stall_i) begin
          w_skid  = imem_rdata_i;
          w_state = HOLD;
        end else if (!stall_i) begin
          w_ld     = 1'b1;
          w_ifid_d = w_valid ? {r_pc, pc_plus4_o, imem_rdata_i, 1'b1}
                             : {ifid_pc_o, ifid_pc_plus4_o, NOP_INST, 1'b0};
          w_pc       = w_valid ? next_pc_i : r_pc;
          w_req_addr = w_valid ? next_pc_i : r_req_addr;
        end
      HOLD:
        if (!stall_i) begin
          w_ld       = 1'b1;
          w_pc       = next_pc_i;
          w_req_addr = next_pc_i;
          w_state    = FETCH;
        end
      DISCARD:
        if (w_valid) begin
          w_req_addr = r_pc;
          w_state    = FETCH;
        end
      default: w_state = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_skid     <= '0;
      r_run      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_req_addr <= w_req_addr;
      r_skid     <= w_skid;
      r_run      <= 1'b1;
    end
  ifid_reg #(.W(W), .CLR(IFID_CLR)) u_ifid (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_ld),
    .i_clr (flush_i),
    .i_d   (w_ifid_d),
    .o_q   (w_ifid_q)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks plus per-cycle rule checks against a latency-configurable memory
module tb_fetch_stage;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst = 0;
  logic stall = 0, flush = 0, redirect = 0;
  logic [31:0] tgt = 0;
  int lat = 0, mem_cnt = 0, n_asrt = 0, n_fail = 0;
  logic mon = 0, prev_out = 0;
  logic [31:0] prev_addr = 0;
  logic [31:0] next_pc, pc, pc4, addr, rdata, ifid_pc, ifid_pc4, ifid_inst;
  logic req, valid, ifid_v;
  logic [31:0] pc2, pc42, addr2, ifid_pc2, ifid_pc42, ifid_inst2;
  logic req2, ifid_v2;

  always #5 clk = ~clk;

  assign next_pc = redirect ? tgt : pc4;
  assign valid   = req && (mem_cnt >= lat);
  assign rdata   = valid ? (addr ^ K) : 32'hDEAD_BEEF;

  always @(posedge clk or posedge rst)
    if (rst) mem_cnt <= 0;
    else if (req) mem_cnt <= valid ? 0 : mem_cnt + 1;

  fetch_stage dut (
    .clk(clk), .rst(rst), .next_pc_i(next_pc), .stall_i(stall), .flush_i(flush),
    .pc_o(pc), .pc_plus4_o(pc4), .imem_req_o(req), .imem_addr_o(addr),
    .imem_rdata_i(rdata), .imem_valid_i(valid),
    .ifid_pc_o(ifid_pc), .ifid_pc_plus4_o(ifid_pc4), .ifid_inst_o(ifid_inst), .ifid_valid_o(ifid_v)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .next_pc_i(pc42), .stall_i(1'b0), .flush_i(1'b0),
    .pc_o(pc2), .pc_plus4_o(pc42), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_rdata_i(addr2 ^ K), .imem_valid_i(req2),
    .ifid_pc_o(ifid_pc2), .ifid_pc_plus4_o(ifid_pc42), .ifid_inst_o(ifid_inst2), .ifid_valid_o(ifid_v2)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_asrt++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int l);
    rst = 1; stall = 0; flush = 0; redirect = 0; lat = l;
    #1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  // every-cycle rules: adder, IF/ID content coherence, request held until answered
  always @(negedge clk)
    if (rst || !mon) prev_out = 0;
    else begin
      chk("pc_plus4", pc4, pc + 32'd4);
      if (ifid_v) begin
        chk("ifid_inst_data", ifid_inst, ifid_pc ^ K);
        chk("ifid_pc_plus4", ifid_pc4, ifid_pc + 32'd4);
      end else chk("bubble_inst", ifid_inst, NOP);
      if (prev_out) begin
        chk("addr_held", addr, prev_addr);
        chk("req_held", {31'b0, req}, 32'd1);
      end
      prev_out  = req && !valid;
      prev_addr = addr;
    end

  initial begin
    #1;
    // reset and zero-latency stream
    do_reset(0);
    mon = 1;
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ifid_valid", {31'b0, ifid_v}, 0);
    chk("rst_ifid_inst", ifid_inst, NOP);
    chk("rst_ifid_pc", ifid_pc, 0);
    chk("wrap_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc42, 0);
    step();
    chk("s1_req", {31'b0, req}, 1);
    chk("s1_addr", addr, 0);
    chk("s1_ifid_valid", {31'b0, ifid_v}, 0);
    step();
    chk("s2_ifid_pc", ifid_pc, 0);
    chk("s2_ifid_valid", {31'b0, ifid_v}, 1);
    chk("s2_ifid_inst", ifid_inst, 32'hA5A5_0000);
    chk("wrap_ifid_pc", ifid_pc2, 32'hFFFF_FFFC);
    chk("wrap_ifid_pc4", ifid_pc42, 0);
    chk("wrap_addr", addr2, 0);
    chk("wrap_pc_next", pc2, 0);
    step();
    chk("s3_ifid_pc", ifid_pc, 4);
    step();
    chk("s4_ifid_pc", ifid_pc, 8);
    step();
    chk("s5_ifid_pc", ifid_pc, 12);
    chk("s5_ifid_inst", ifid_inst, 32'hA5A5_000C);
    chk("s5_pc", pc, 16);

    // stall in FETCH at PC=8
    do_reset(0);
    step(3);
    chk("st_pre_pc", pc, 8);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_ifid_pc", ifid_pc, 4);
      chk("st_pc", pc, 8);
      chk("st_req", {31'b0, req}, 0);
    end
    stall = 0;
    step();
    chk("st_rel_ifid_pc", ifid_pc, 8);
    chk("st_rel_inst", ifid_inst, 32'hA5A5_0008);
    chk("st_rel_pc", pc, 12);
    chk("st_rel_req", {31'b0, req}, 1);

    // flush with a response pending, latency 2
    do_reset(2);
    step(7);
    chk("fl_pre_ifid_pc", ifid_pc, 4);
    chk("fl_pre_addr", addr, 8);
    chk("fl_pre_valid", {31'b0, valid}, 0);
    flush = 1; redirect = 1; tgt = 32'h100;
    step();
    flush = 0; redirect = 0;
    chk("fl_addr_old", addr, 8);
    chk("fl_pc", pc, 32'h100);
    chk("fl_ifid_valid", {31'b0, ifid_v}, 0);
    step();
    chk("fl_drop_valid", {31'b0, valid}, 1);
    chk("fl_drop_addr", addr, 8);
    step();
    chk("fl_new_addr", addr, 32'h100);
    chk("fl_wait_valid0", {31'b0, ifid_v}, 0);
    step(2);
    chk("fl_wait_valid2", {31'b0, ifid_v}, 0);
    step();
    chk("fl_ifid_pc", ifid_pc, 32'h100);
    chk("fl_ifid_inst", ifid_inst, 32'hA5A5_0100);
    chk("fl_ifid_valid1", {31'b0, ifid_v}, 1);

    // flush and stall together while in HOLD
    do_reset(0);
    step(3);
    stall = 1;
    step();
    chk("fh_hold_req", {31'b0, req}, 0);
    flush = 1; redirect = 1; tgt = 32'h200;
    step();
    chk("fh_ifid_valid", {31'b0, ifid_v}, 0);
    chk("fh_ifid_inst", ifid_inst, NOP);
    chk("fh_ifid_pc", ifid_pc, 0);
    chk("fh_pc", pc, 32'h200);
    chk("fh_addr", addr, 32'h200);
    chk("fh_req", {31'b0, req}, 1);
    flush = 0; stall = 0; redirect = 0;
    step();
    chk("fh_next_ifid_pc", ifid_pc, 32'h200);
    chk("fh_next_inst", ifid_inst, 32'hA5A5_0200);

    // asynchronous reset while in DISCARD
    do_reset(2);
    step();
    flush = 1; redirect = 1; tgt = 32'h300;
    step();
    flush = 0; redirect = 0;
    chk("ar_pc", pc, 32'h300);
    chk("ar_addr", addr, 0);
    #1 rst = 1;
    #1;
    chk("ar_req", {31'b0, req}, 0);
    chk("ar_pc_rst", pc, 0);
    chk("ar_addr_rst", addr, 0);
    chk("ar_ifid_valid", {31'b0, ifid_v}, 0);
    chk("ar_ifid_inst", ifid_inst, NOP);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
